// File: rtl/fpmul_issue64.sv
// Issue/credit wrapper around an external fixed-latency 64-bit multiplier.
// Results return through a tagged, strictly in-order result FIFO.
module fpmul_issue64 #(
  parameter int MUL_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_A,
  input  logic [63:0] in_B,
  input  logic        in_rnd,
  input  logic [3:0]  in_tag,
  output logic [63:0] mul_A,
  output logic [63:0] mul_B,
  output logic        mul_rnd,
  input  logic [63:0] mul_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_tag,
  output logic        busy
);

  localparam int PIPE = MUL_LAT + 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OW   = 8;

  logic [PIPE-1:0] vld_pipe;
  logic [3:0]      tag_pipe [PIPE];
  logic [63:0]     data_mem [DEPTH];
  logic [3:0]      tag_mem  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   inflight;
  logic [OW-1:0]   occupancy;
  logic            issue;
  logic            push;
  logic            pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Valid never waits on ready; in_ready depends only on state and rst.
  assign issue = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign push  = vld_pipe[PIPE-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE; i++) begin
      inflight = inflight + OW'(vld_pipe[i]);
    end
  end

  // Credit covers the whole round trip; a pop in this cycle frees credit next cycle.
  assign occupancy = OW'(fifo_count) + inflight;
  assign in_ready  = !rst && (occupancy < OW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_A   <= '0;
      mul_B   <= '0;
      mul_rnd <= 1'b0;
    end else if (issue) begin
      mul_A   <= in_A;
      mul_B   <= in_B;
      mul_rnd <= in_rnd;
    end
  end

  // Valid/tag shadow of the multiplier; the last stage lines up with mul_res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < PIPE; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      vld_pipe    <= {vld_pipe[PIPE-2:0], issue};
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < PIPE; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mul_res;
      tag_mem[wr_ptr]  <= tag_pipe[PIPE-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_tag   = out_valid ? tag_mem[rd_ptr]  : '0;
  assign busy      = (inflight != '0) || (fifo_count != '0);

  // The credit rule means a full FIFO can never have a result arriving.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (fifo_count < CW'(DEPTH)));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fpmul_issue64.sv
// Bench for fpmul_issue64: a behavioural two-register multiplier, a cycle-level
// reference model of credit/latency, and an expected-result queue.
module tb_fpmul_issue64;

  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 2;
  localparam int LAT     = MUL_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_A = '0;
  logic [63:0] in_B = '0;
  logic        in_rnd = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [63:0] mul_A;
  logic [63:0] mul_B;
  logic        mul_rnd;
  logic [63:0] mul_res = '0;
  logic [63:0] mul_stage = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [67:0] exp_q[$];
  int          avail_q[$];

  always #5 clk = ~clk;

  fpmul_issue64 #(.MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_rnd(in_rnd), .in_tag(in_tag),
    .mul_A(mul_A), .mul_B(mul_B), .mul_rnd(mul_rnd), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  // Sign/exponent(bias 0x200)/53-bit mantissa with hidden one; truncate or round-half-up.
  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b, input logic r);
    logic [107:0] p;
    logic [52:0]  m;
    logic [9:0]   e;
    logic         g;
    p = {54'd0, 1'b1, a[52:0]} * {54'd0, 1'b1, b[52:0]};
    e = a[62:53] + b[62:53] - 10'h200;
    if (p[107]) begin
      m = p[106:54];
      g = p[53];
      e = e + 10'd1;
    end else begin
      m = p[105:53];
      g = p[52];
    end
    if (r) m = m + 53'(g);
    return {a[63] ^ b[63], e, m};
  endfunction

  // External multiplier: combinational inputs, result after two registers.
  always @(posedge clk) begin
    mul_stage <= fp_mul(mul_A, mul_B, mul_rnd);
    mul_res   <= mul_stage;
  end

  function automatic logic exp_ready();
    return exp_q.size() < DEPTH;
  endfunction

  function automatic logic exp_valid();
    if (exp_q.size() == 0) return 1'b0;
    return cyc >= avail_q[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one cycle, records accept/pop as seen before the edge, then advances.
  task automatic drive_cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                             input logic r, input logic [3:0] t, input logic ordy,
                             output logic acc, output logic popd, output logic [67:0] got);
    in_valid  = v;
    in_A      = a;
    in_B      = b;
    in_rnd    = r;
    in_tag    = t;
    out_ready = ordy;
    acc  = v && in_ready;
    popd = out_valid && ordy;
    got  = {out_tag, out_data};
    if (acc) begin
      exp_q.push_back({t, fp_mul(a, b, r)});
      avail_q.push_back(cyc + LAT);
    end
    tick();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, out_valid, busy, mul_rnd} !== 4'b0 || mul_A !== 64'd0 || mul_B !== 64'd0 ||
        out_data !== 64'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b rnd=%b mulA=%h mulB=%h data=%h tag=%h required all 0",
               in_ready, out_valid, busy, mul_rnd, mul_A, mul_B, out_data, out_tag);
    end
    rst = 1'b0;
    exp_q.delete();
    avail_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_single_op(input string name, input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] t, input logic [63:0] exp_data);
    logic acc, popd;
    logic [67:0] got;
    int seen;
    seen = 0;
    drive_cycle(1'b1, a, b, 1'b0, t, 1'b1, acc, popd, got);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept got %b required 1", name, acc);
    end
    for (int k = 1; k <= LAT + 3; k++) begin
      drive_cycle(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b1, acc, popd, got);
      checks++;
      if (popd) begin
        seen++;
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(avail_q.pop_front());
        end
        if (k != LAT || got !== {t, exp_data}) begin
          errors++;
          $display("FAIL %s_result got cycle %0d tag/data %h required cycle %0d %h", name, k, got, LAT, {t, exp_data});
        end
      end else if (got !== 68'd0) begin
        errors++;
        $display("FAIL %s_empty_zero got %h required 0 at cycle %0d", name, got, k);
      end
    end
    checks++;
    if (seen != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got results=%0d busy=%b required 1 and 0", name, seen, busy);
    end
  endtask

  task automatic test_backpressure();
    logic acc, popd, prev;
    logic [67:0] got, item;
    int n_acc, pops;
    n_acc = 0;
    pops = 0;
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (in_ready !== (k < 4)) begin
        errors++;
        $display("FAIL bp_ready cycle %0d got %b required %b", k, in_ready, (k < 4));
      end
      drive_cycle(1'b1, rand64(), rand64(), 1'($urandom_range(0, 1)), 4'(n_acc), 1'b0, acc, popd, got);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != 4) begin
      errors++;
      $display("FAIL bp_accepted got %0d required 4", n_acc);
    end
    for (int k = 0; k < 12; k++) begin
      if (pops == 1 && prev) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_after_pop got %b required 1", in_ready);
        end
      end
      drive_cycle(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b1, acc, popd, got);
      prev = popd;
      if (popd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_result got %h required none", got);
        end else begin
          item = exp_q.pop_front();
          void'(avail_q.pop_front());
          if (got !== item || got[67:64] !== 4'(pops)) begin
            errors++;
            $display("FAIL bp_result got %h required %h (tag %0d)", got, item, pops);
          end
        end
        pops++;
      end
    end
    checks++;
    if (pops != 4) begin
      errors++;
      $display("FAIL bp_drain got %0d results required 4", pops);
    end
  endtask

  // Cycle-exact comparison of control outputs against the credit/latency model.
  task automatic run_mixed(input string name, input int n_ops, input int max_cycles,
                           input int pv, input int pr);
    logic acc, popd, v, ordy;
    logic [67:0] got, item;
    int n_acc;
    n_acc = 0;
    for (int k = 0; k < max_cycles; k++) begin
      if (n_acc >= n_ops && exp_q.size() == 0) break;
      checks++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid() || busy !== (exp_q.size() != 0) ||
          (out_valid === 1'b0 && {out_tag, out_data} !== 68'd0)) begin
        errors++;
        $display("FAIL %s_ctrl cycle %0d got rdy=%b vld=%b busy=%b head=%h required rdy=%b vld=%b busy=%b",
                 name, k, in_ready, out_valid, busy, {out_tag, out_data},
                 exp_ready(), exp_valid(), (exp_q.size() != 0));
      end
      v    = (n_acc < n_ops) && ($urandom_range(1, 100) <= pv);
      ordy = (n_acc >= n_ops) || ($urandom_range(1, 100) <= pr);
      drive_cycle(v, rand64(), rand64(), 1'($urandom_range(0, 1)), 4'(n_acc), ordy, acc, popd, got);
      if (acc) n_acc++;
      if (popd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_result got %h required none", name, got);
        end else begin
          item = exp_q.pop_front();
          void'(avail_q.pop_front());
          if (got !== item) begin
            errors++;
            $display("FAIL %s_result got %h required %h", name, got, item);
          end
        end
      end
    end
    checks++;
    if (n_acc != n_ops || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_complete got issued=%0d pending=%0d busy=%b required %0d 0 0",
               name, n_acc, exp_q.size(), busy, n_ops);
    end
  endtask

  task automatic test_stream();
    run_mixed("stream", 16, 80, 100, 100);
  endtask

  task automatic test_full_push_pop();
    run_mixed("fill", 60, 600, 90, 25);
    run_mixed("mixed", 120, 800, 70, 70);
  endtask

  task automatic test_reset_midflight();
    logic acc, popd;
    logic [67:0] got;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, rand64(), rand64(), 1'b0, 4'(k), 1'b1, acc, popd, got);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_accept op %0d got %b required 1", k, acc);
      end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || mul_A !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_during got rdy=%b vld=%b busy=%b mulA=%h required 0 0 0 0",
               in_ready, out_valid, busy, mul_A);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    avail_q.delete();
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after cycle %0d got vld=%b busy=%b rdy=%b required 0 0 1",
                 k, out_valid, busy, in_ready);
      end
      drive_cycle(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b1, acc, popd, got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op("single", 64'h4000000000000000, 64'h4020000000000000, 4'd5, 64'h4020000000000000);
    test_single_op("sign",   64'hC000000000000000, 64'h4000000000000000, 4'd9, 64'hC000000000000000);
    test_backpressure();
    test_stream();
    test_reset_midflight();
    test_full_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
